// File: rtl/frame_draw_scheduler_pkg.sv
// Shared constants for the frame draw scheduler: screen and sprite geometry,
// bus widths and the FSM state encoding.
package frame_draw_scheduler_pkg;
  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;
  localparam int SPR_W = 8;
  localparam int SPR_H = 8;
  localparam int COL_W = 3;

  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int AW  = 15;
  localparam int SXW = 3;
  localparam int SYW = 3;
  localparam int SAW = 6;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_BG_SCAN   = 3'd1;
  localparam logic [2:0] ST_BG_FLUSH  = 3'd2;
  localparam logic [2:0] ST_NOTE_WAIT = 3'd3;
  localparam logic [2:0] ST_NOTE_DRAW = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    BG_SCAN   = ST_BG_SCAN,
    BG_FLUSH  = ST_BG_FLUSH,
    NOTE_WAIT = ST_NOTE_WAIT,
    NOTE_DRAW = ST_NOTE_DRAW
  } state_t;

  localparam logic [AW-1:0]  BG_LAST  = AW'(X_MAX * Y_MAX - 1);
  localparam logic [SAW-1:0] SPR_LAST = SAW'(SPR_W * SPR_H - 1);
endpackage

// File: rtl/frame_draw_scheduler_if.sv
// Bundle of frame tick, background ROM, note engine and framebuffer signals.
// master = scheduler side, slave = surrounding system.
interface frame_draw_scheduler_if;
  import frame_draw_scheduler_pkg::*;

  logic             frame_tick;
  logic             enable;
  logic [AW-1:0]    bg_address;
  logic [COL_W-1:0] bg_colour;
  logic             note_req;
  logic [XW-1:0]    note_x;
  logic [YW-1:0]    note_y;
  logic [COL_W-1:0] note_colour;
  logic             note_ack;
  logic [XW-1:0]    vga_x;
  logic [YW-1:0]    vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             overrun;

  modport master (
    input  frame_tick, enable, bg_colour, note_req, note_x, note_y, note_colour,
    output bg_address, note_ack, vga_x, vga_y, vga_colour, vga_plot, busy, overrun
  );

  modport slave (
    output frame_tick, enable, bg_colour, note_req, note_x, note_y, note_colour,
    input  bg_address, note_ack, vga_x, vga_y, vga_colour, vga_plot, busy, overrun
  );
endinterface

// File: rtl/frame_draw_scheduler_raster_walker.sv
// Raster x/y counter (x fastest) that wraps to (0,0) after the last pixel,
// with a combinational linear address y*W+x of the current position.
module raster_walker #(
  parameter int W  = 160,
  parameter int H  = 120,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr
);
  logic x_end;
  logic y_end;

  assign x_end = (x == XW'(W - 1));
  assign y_end = (y == YW'(H - 1));
  assign addr  = AW'(y) * AW'(W) + AW'(x);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end
endmodule

// File: rtl/frame_draw_scheduler.sv
// Sole writer of the framebuffer port: per enabled frame tick, scans the background
// ROM (pixel plotted one cycle after its address) then draws queued 8x8 note sprites.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
(
  input logic                    CLK,
  input logic                    resetn,
  frame_draw_scheduler_if.master bus
);
  state_t state, state_nxt;

  logic             start;
  logic             bg_clr, bg_step, spr_clr, spr_step;
  logic [XW-1:0]    bg_x, ix, nx;
  logic [YW-1:0]    bg_y, iy, ny;
  logic [AW-1:0]    bg_addr;
  logic [SXW-1:0]   spr_x;
  logic [SYW-1:0]   spr_y;
  logic [SAW-1:0]   spr_addr;
  logic [COL_W-1:0] nc;
  logic [XW:0]      sx;
  logic [YW:0]      sy;

  assign start    = (state == IDLE) && bus.frame_tick && bus.enable;
  assign bg_clr   = (state == IDLE) && !start;
  assign bg_step  = start || (state == BG_SCAN);
  assign spr_clr  = (state != NOTE_DRAW);
  assign spr_step = (state == NOTE_DRAW);
  // one bit wider than the screen so sprites hanging off the edge clip, not wrap
  assign sx = {1'b0, nx} + (XW+1)'(spr_x);
  assign sy = {1'b0, ny} + (YW+1)'(spr_y);

  raster_walker #(.W(X_MAX), .H(Y_MAX), .XW(XW), .YW(YW), .AW(AW)) u_bg (
    .clk(CLK), .resetn(resetn), .clr(bg_clr), .step(bg_step),
    .x(bg_x), .y(bg_y), .addr(bg_addr)
  );

  raster_walker #(.W(SPR_W), .H(SPR_H), .XW(SXW), .YW(SYW), .AW(SAW)) u_spr (
    .clk(CLK), .resetn(resetn), .clr(spr_clr), .step(spr_step),
    .x(spr_x), .y(spr_y), .addr(spr_addr)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = BG_SCAN;
      BG_SCAN:   if (bg_addr == BG_LAST) state_nxt = BG_FLUSH;
      BG_FLUSH:  state_nxt = NOTE_WAIT;
      NOTE_WAIT: state_nxt = bus.note_req ? NOTE_DRAW : IDLE;
      NOTE_DRAW: if (spr_addr == SPR_LAST) state_nxt = NOTE_WAIT;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // ix/iy hold the position of the address currently on bg_address, so the
  // pixel is written one cycle later alongside the ROM data for it.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      bus.bg_address <= '0;
      bus.note_ack   <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
      ix             <= '0;
      iy             <= '0;
      nx             <= '0;
      ny             <= '0;
      nc             <= '0;
    end else begin
      bus.vga_plot <= 1'b0;
      bus.note_ack <= 1'b0;
      bus.busy     <= (state_nxt != IDLE);
      if (bus.frame_tick && bus.busy) bus.overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            bus.bg_address <= bg_addr;
            ix             <= bg_x;
            iy             <= bg_y;
          end
        end
        BG_SCAN: begin
          bus.bg_address <= bg_addr;
          ix             <= bg_x;
          iy             <= bg_y;
          bus.vga_x      <= ix;
          bus.vga_y      <= iy;
          bus.vga_colour <= bus.bg_colour;
          bus.vga_plot   <= 1'b1;
        end
        BG_FLUSH: begin
          bus.vga_x      <= ix;
          bus.vga_y      <= iy;
          bus.vga_colour <= bus.bg_colour;
          bus.vga_plot   <= 1'b1;
        end
        NOTE_WAIT: begin
          if (bus.note_req) begin
            nx           <= bus.note_x;
            ny           <= bus.note_y;
            nc           <= bus.note_colour;
            bus.note_ack <= 1'b1;
          end
        end
        NOTE_DRAW: begin
          bus.vga_x      <= sx[XW-1:0];
          bus.vga_y      <= sy[YW-1:0];
          bus.vga_colour <= nc;
          bus.vga_plot   <= (sx < (XW+1)'(X_MAX)) && (sy < (YW+1)'(Y_MAX));
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Scoreboard bench: expected plots are queued as stimulus is issued and a
// monitor pops/compares on every vga_plot; frame-level timing checked per frame.
module tb_frame_draw_scheduler;
  import frame_draw_scheduler_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   passed = 0;
  pix_t exp_q[$];
  pix_t nq[$];

  frame_draw_scheduler_if bus();

  frame_draw_scheduler dut (
    .CLK(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom(input logic [14:0] a);
    return a[2:0] ^ a[9:7] ^ a[14:12];
  endfunction

  assign bus.bg_colour = rom(bus.bg_address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.bg_address, bus.note_ack, bus.vga_x, bus.vga_y, bus.vga_colour,
                bus.vga_plot, bus.busy, bus.overrun});
  endfunction

  function automatic pix_t mkpix(input int x, input int y, input logic [2:0] c);
    pix_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.c = c;
    return p;
  endfunction

  // monitor: every plot must match the head of the expected queue
  initial begin : monitor
    pix_t e;
    forever begin
      @(negedge clk);
      if (bus.vga_plot === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL plot_extra: got x=%0d y=%0d c=%0d required no plot",
                   bus.vga_x, bus.vga_y, bus.vga_colour);
        end else begin
          e = exp_q.pop_front();
          check("plot", 64'({bus.vga_x, bus.vga_y, bus.vga_colour}), 64'(e));
        end
      end
    end
  end

  // One full frame with the notes in nq; optional extra tick / enable drop at cycle k.
  task automatic run_frame(input int tick2_k, input int drop_en_k);
    int n = nq.size();
    int bg_err = 0, nplots = 0, first_k = 0, bg_last_k = 0, fall_k = 0;
    int ov_k = 0, restart = 0, nacks = 0, ack_err = 0, exp_vis = 0;
    for (int y = 0; y < Y_MAX; y++)
      for (int x = 0; x < X_MAX; x++)
        exp_q.push_back(mkpix(x, y, rom(15'(y * X_MAX + x))));
    foreach (nq[i])
      for (int dy = 0; dy < SPR_H; dy++)
        for (int dx = 0; dx < SPR_W; dx++)
          if (int'(nq[i].x) + dx < X_MAX && int'(nq[i].y) + dy < Y_MAX) begin
            exp_q.push_back(mkpix(int'(nq[i].x) + dx, int'(nq[i].y) + dy, nq[i].c));
            exp_vis++;
          end
    bus.note_req = (n > 0);
    if (n > 0) begin
      bus.note_x = nq[0].x; bus.note_y = nq[0].y; bus.note_colour = nq[0].c;
    end
    @(negedge clk);
    bus.enable = 1'b1;
    bus.frame_tick = 1'b1;
    for (int k = 1; k <= 19202 + 65 * n + 10; k++) begin
      @(negedge clk);
      if (k <= 19200 && bus.bg_address !== 15'(k - 1)) bg_err++;
      if (bus.vga_plot) begin
        nplots++;
        if (first_k == 0) first_k = k;
        if (nplots == 19200) bg_last_k = k;
      end
      if (bus.overrun && ov_k == 0) ov_k = k;
      if (bus.note_ack) begin
        if (k != 19202 + 65 * nacks) ack_err++;
        nacks++;
        if (nq.size() > 0) void'(nq.pop_front());
        if (nq.size() > 0) begin
          bus.note_x = nq[0].x; bus.note_y = nq[0].y; bus.note_colour = nq[0].c;
        end else begin
          bus.note_req = 1'b0;
        end
      end
      if (fall_k == 0 && !bus.busy) fall_k = k;
      else if (fall_k != 0 && bus.busy) restart++;
      bus.frame_tick = (k == tick2_k);
      if (k == drop_en_k) bus.enable = 1'b0;
      if (fall_k != 0 && k >= fall_k + 2) break;
    end
    check("bg_address_seq_errors", 64'(bg_err), 0);
    check("first_plot_cycle", 64'(first_k), 2);
    check("bg_last_plot_cycle", 64'(bg_last_k), 19201);
    check("plot_count", 64'(nplots), 64'(19200 + exp_vis));
    check("busy_fall_cycle", 64'(fall_k), 64'(19202 + 65 * n));
    check("no_restart", 64'(restart), 0);
    check("ack_count", 64'(nacks), 64'(n));
    check("ack_spacing_errors", 64'(ack_err), 0);
    check("overrun_cycle", 64'(ov_k), 64'(tick2_k > 0 ? tick2_k + 1 : 0));
    check("sb_drain", 64'(exp_q.size()), 0);
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.enable = 1'b0; bus.note_req = 1'b0;
    bus.note_x = '0; bus.note_y = '0; bus.note_colour = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    resetn = 1'b1;

    // reset in the middle of a background scan, after an overrun
    for (int p = 0; p <= 48; p++) exp_q.push_back(mkpix(p, 0, rom(15'(p))));
    @(negedge clk);
    bus.enable = 1'b1;
    bus.frame_tick = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 11) check("overrun_set_midscan", 64'(bus.overrun), 1);
      bus.frame_tick = (k == 10);
      if (k == 50) resetn = 1'b0;
    end
    @(negedge clk);
    check("midscan_reset_outputs", outs(), 0);
    check("midscan_sb_drain", 64'(exp_q.size()), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("busy_after_release", 64'(bus.busy), 0);

    // plain frame with an overrun tick during the scan
    run_frame(500, 0);
    check("overrun_sticky", 64'(bus.overrun), 1);

    // tick with enable low is ignored
    @(negedge clk);
    bus.enable = 1'b0;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("gated_tick_busy", 64'(bus.busy), 0);
    check("gated_tick_plot", 64'(bus.vga_plot), 0);
    check("gated_tick_addr", 64'(bus.bg_address), 19199);
    @(negedge clk);
    check("gated_tick_busy_later", 64'(bus.busy), 0);

    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // single note, enable dropped mid-frame
    nq.push_back(mkpix(10, 20, 3'b100));
    run_frame(0, 1000);

    // clipped note then two more back-to-back; tick on the final NOTE_WAIT->IDLE edge
    nq.push_back(mkpix(156, 118, 3'b010));
    nq.push_back(mkpix(30, 40, 3'b001));
    nq.push_back(mkpix(100, 60, 3'b110));
    run_frame(19201 + 65 * 3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
Sequences all writes into the VGA adapter's 160x120 framebuffer write port, one redraw per frame tick. On each 64 Hz frame tick it raster-scans the background ROM into the framebuffer. It then grants the write port to the note engine, one 8x8 note sprite per request, and returns to idle. It is the only driver of the adapter's x/y/colour/plot inputs.

Parameters:
X_MAX, 160, screen width in pixels (x range 0..X_MAX-1)
Y_MAX, 120, screen height in pixels (y range 0..Y_MAX-1)
SPR_W, 8, note sprite width
SPR_H, 8, note sprite height

Ports:
CLK  in  1  system clock (50 MHz)
resetn  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse from the 64 Hz enable counter
enable  in  1  game is in the playing state; gates the start of a frame
bg_address  out  15  background ROM address, y*X_MAX+x
bg_colour  in  3  ROM data, valid one cycle after bg_address
note_req  in  1  note engine requests a sprite draw (level)
note_x  in  8  sprite top-left x
note_y  in  7  sprite top-left y
note_colour  in  3  sprite colour
note_ack  out  1  one-cycle pulse: request accepted, note fields latched
vga_x  out  8  framebuffer write x
vga_y  out  7  framebuffer write y
vga_colour  out  3  framebuffer write colour
vga_plot  out  1  framebuffer write strobe
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- All outputs are registered. On resetn=0 at a clock edge, every output and internal register goes to 0 and the state goes to IDLE; this applies at any point mid-frame. overrun is cleared only by reset.
- States: IDLE, BG_SCAN, BG_FLUSH, NOTE_WAIT, NOTE_DRAW.
- IDLE -> BG_SCAN when frame_tick & enable at an edge. bg_address=0 after that edge. If frame_tick arrives with enable=0, it is ignored.
- BG_SCAN: each cycle, bg_address advances in raster order (x fastest, y wraps at X_MAX, then Y_MAX).
  - The x/y of each issued address is delayed one cycle. Then vga_plot=1 with vga_colour=bg_colour at that delayed x/y, which gives a one-cycle ROM latency.
  - Once bg_address=19199 has been issued, the state goes to BG_FLUSH. BG_FLUSH writes the last pixel (159,119), then goes to NOTE_WAIT.
  - A frame therefore produces exactly 19200 plots. The first plot is seen the edge after bg_address=0.
- NOTE_WAIT:
  - If note_req=1, latch note_x/y/colour, pulse note_ack for one cycle and go to NOTE_DRAW.
  - If note_req=0, go to IDLE.
  - The requester must present its next note, or drop note_req, by the cycle after note_ack. note_req must not be re-sampled in the ack cycle, because NOTE_DRAW is entered.
- NOTE_DRAW: iterate dx 0..SPR_W-1 (fastest) and dy 0..SPR_H-1, which is 64 cycles.
  - vga_x=note_x+dx and vga_y=note_y+dy, computed at 9/8-bit width with no wrap.
  - vga_plot=1 only if the computed x<X_MAX and y<Y_MAX. Off-screen pixels are clipped (plot=0) but still take their cycle.
  - After the last cycle (dx=7, dy=7), go to NOTE_WAIT.
- vga_plot=0 in IDLE and NOTE_WAIT. In those states vga_x, vga_y and vga_colour hold their last values.
- If frame_tick=1 while busy=1: set overrun=1. The tick is dropped and the current frame is not restarted.
- enable falling mid-frame has no effect; the frame completes.
- Simultaneous frame_tick and the last NOTE_WAIT->IDLE transition: the tick counts as busy, so overrun is set and the tick is dropped.

Decomposition:
- Shared package: the state encoding (3-bit localparams), X_MAX/Y_MAX, SPR_W/SPR_H and the colour width (3).
- One sub-module, raster_walker: an x/y counter with enable, wrap and done flag, plus an address = y*X_MAX+x computation. It is instantiated twice: at 160x120 for the background and at 8x8 for sprites.

Test Plan:
1. Reset: resetn=0 for 2 cycles mid-BG_SCAN -> all outputs 0, state IDLE; busy=0 on the cycle after release.
2. Plain frame: enable=1, frame_tick pulse, note_req=0 ->
   - bg_address runs 0..19199 in order;
   - exactly 19200 vga_plot pulses, the first at (0,0) one cycle after bg_address=0 and the last at (159,119) with the ROM colour;
   - busy falls 19202 cycles after the tick; note_ack never pulses.
3. One note: note_req held with (10,20,3'b100) and dropped after ack ->
   - one note_ack pulse after BG_FLUSH;
   - 64 plots covering x 10..17, y 20..27, colour 3'b100;
   - then IDLE.
4. Clipping: note at (156,118) -> 64 NOTE_DRAW cycles, but only 8 plots, covering x 156..159 and y 118..119.
5. Back-to-back notes: three requests, each presented the cycle after the previous ack -> three acks spaced 65 cycles apart and 192 plots in request order.
6. Overrun and gating:
   - frame_tick during BG_SCAN -> overrun=1 and stays 1; the scan continues unbroken.
   - frame_tick with enable=0 in IDLE -> no state change, busy=0.
